// File: rtl/bsw_evq_pkg.sv
// bsw_evq_pkg: debounce FSM encodings, event-word layout and register map for bsw_evq
package bsw_evq_pkg;
  localparam logic [1:0] ST_UP     = 2'd0;
  localparam logic [1:0] ST_CHK_DN = 2'd1;
  localparam logic [1:0] ST_DOWN   = 2'd2;
  localparam logic [1:0] ST_CHK_UP = 2'd3;
  localparam int VALID_BIT = 31;
  localparam int TS_MSB    = 23;
  localparam int TS_LSB    = 8;
  localparam int TYPE_BIT  = 2;
  localparam logic ADDR_EVT = 1'b0;
  localparam logic ADDR_CSR = 1'b1;
  localparam int CTL_IEN   = 0;
  localparam int CTL_FLUSH = 1;
  function automatic logic [31:0] ev_word(input logic [15:0] ts, input logic press, input logic [1:0] key);
    ev_word = '0;
    ev_word[VALID_BIT] = 1'b1;
    ev_word[TS_MSB:TS_LSB] = ts;
    ev_word[TYPE_BIT] = press;
    ev_word[1:0] = key;
  endfunction
endpackage

// File: rtl/bsw_debounce.sv
// bsw_debounce: 2-flop synchroniser plus UP/CHK_DN/DOWN/CHK_UP debounce FSM for one active-low key
//   key_n_i raw key (low = pressed); level_o debounced level (1 = pressed);
//   ev_o one-cycle event pulse; press_o event type (1 = press), valid with ev_o
module bsw_debounce
  import bsw_evq_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic level_o,
  output logic ev_o,
  output logic press_o
);
  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
  logic [1:0] sync_q;
  logic [1:0] st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic p;
  assign p = sync_q[1];
  assign level_o = (st_q == ST_DOWN) || (st_q == ST_CHK_UP);
  // Counter only runs in the CHK states, so entering one always starts from 0
  always_comb begin
    st_d = st_q;
    cnt_d = '0;
    ev_o = 1'b0;
    press_o = 1'b0;
    case (st_q)
      ST_UP:     st_d = p ? ST_CHK_DN : ST_UP;
      ST_CHK_DN: begin
        cnt_d = cnt_q + 1'b1;
        st_d = !p ? ST_UP : (cnt_q == LAST) ? ST_DOWN : ST_CHK_DN;
        ev_o = p && (cnt_q == LAST);
        press_o = ev_o;
      end
      ST_DOWN:   st_d = !p ? ST_CHK_UP : ST_DOWN;
      default: begin
        cnt_d = cnt_q + 1'b1;
        st_d = p ? ST_DOWN : (cnt_q == LAST) ? ST_UP : ST_CHK_UP;
        ev_o = !p && (cnt_q == LAST);
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      st_q <= ST_UP;
      cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[0], ~key_n_i};
      st_q <= st_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/bsw_evq.sv
// bsw_evq: debounced 4-key event controller with event FIFO, bus registers and level irq
//   bus: stb/we/addr/data_in in, data_out (combinational)/ack out; irq level out; keys_n raw active-low keys
//   optional BSW_EVQ_TIMESTAMP_EN: 16-bit cycle/1024 timestamp in event bits [23:8]
module bsw_evq
  import bsw_evq_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DEB_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        irq,
  input  logic [3:0]  keys_n
);
  localparam int AW = $clog2(DEPTH);
  logic [3:0] lvl, ev, press;
  genvar k;
  for (k = 0; k < 4; k++) begin : g_key
    bsw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk(clk), .rst_n(rst_n), .key_n_i(keys_n[k]),
      .level_o(lvl[k]), .ev_o(ev[k]), .press_o(press[k])
    );
  end
  logic [3:0] pend_q, pend_d, type_q, type_d, sel;
  logic [1:0] idx;
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q, cnt_d;
  logic ien_q, ovf_q, ovf_d;
  logic [31:0] mem_q [DEPTH];
  logic [15:0] ts;
  logic rd_evt, rd_csr, wr_csr, flush, pop, push, full, acc;
  logic unused_data;
  assign unused_data = ^data_in[31:2];
`ifdef BSW_EVQ_TIMESTAMP_EN
  logic [9:0] pre_q;
  logic [15:0] ts_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      ts_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
      ts_q <= ts_q + 16'(&pre_q);
    end
  end
  assign ts = ts_q;
`else
  assign ts = '0;
`endif
  assign rd_evt = stb & ~we & (addr == ADDR_EVT);
  assign rd_csr = stb & ~we & (addr == ADDR_CSR);
  assign wr_csr = stb & we & (addr == ADDR_CSR);
  assign flush = wr_csr & data_in[CTL_FLUSH];
  assign pop = rd_evt & (cnt_q != '0);
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign push = (|pend_q) & ~flush;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign acc = push & (~full | pop);
  assign idx = pend_q[0] ? 2'd0 : pend_q[1] ? 2'd1 : pend_q[2] ? 2'd2 : 2'd3;
  assign sel = 4'b1 << idx;
  assign pend_d = (flush ? 4'b0 : pend_q & ~sel) | ev;
  assign type_d = (type_q & ~ev) | press;
  assign cnt_d = flush ? '0 : cnt_q + (AW+1)'(acc) - (AW+1)'(pop);
  assign ovf_d = (push & full & ~pop) | (ovf_q & ~rd_csr);
  assign data_out = pop ? mem_q[rp_q] : rd_csr ? {18'b0, 6'(cnt_q), 2'b0, ovf_q, ien_q, lvl} : 32'b0;
  assign ack = stb;
  assign irq = ien_q & (cnt_q != '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      type_q <= '0;
      cnt_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      ovf_q <= 1'b0;
      ien_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      type_q <= type_d;
      cnt_q <= cnt_d;
      wp_q <= flush ? '0 : wp_q + AW'(acc);
      rp_q <= flush ? '0 : rp_q + AW'(pop);
      ovf_q <= ovf_d;
      if (wr_csr) ien_q <= data_in[CTL_IEN];
    end
  end
  always_ff @(posedge clk) begin
    if (acc) mem_q[wp_q] <= ev_word(ts, type_q[idx], idx);
  end
endmodule

// File: tb/tb_bsw_evq.sv
// tb_bsw_evq: scoreboard bench for bsw_evq with DEPTH 8 and DEB_CYCLES 16
module tb_bsw_evq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stb = 1'b0;
  logic we = 1'b0;
  logic addr = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic ack, irq;
  logic [3:0] keys_n = 4'hF;
  int n_tot = 0;
  int n_pass = 0;
  logic [31:0] sb[$];
  always #5 clk = ~clk;
  bsw_evq #(.DEPTH(8), .DEB_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .stb(stb), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .ack(ack), .irq(irq), .keys_n(keys_n)
  );
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic peek(input logic a, output logic [31:0] d);
    stb = 1'b1; we = 1'b0; addr = a;
    #1;
    d = data_out;
    stb = 1'b0;
    #1;
  endtask
  task automatic bus_rd(input logic a, output logic [31:0] d);
    stb = 1'b1; we = 1'b0; addr = a;
    #1;
    d = data_out;
    @(posedge clk);
    #1;
    stb = 1'b0;
  endtask
  task automatic bus_wr(input logic a, input logic [31:0] v);
    stb = 1'b1; we = 1'b1; addr = a; data_in = v;
    @(posedge clk);
    #1;
    stb = 1'b0; we = 1'b0; data_in = '0;
  endtask
  task automatic test_reset;
    logic [31:0] d;
    tick(2);
    n_tot++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
    n_tot++; if (ack !== 1'b0) $display("FAIL reset_ack_idle: got %b want 0", ack); else n_pass++;
    peek(1'b0, d);
    n_tot++; if (d !== 32'h0) $display("FAIL reset_evt: got %h want 0", d); else n_pass++;
    peek(1'b1, d);
    n_tot++; if (d !== 32'h0) $display("FAIL reset_csr: got %h want 0", d); else n_pass++;
    rst_n = 1'b1;
    tick(1);
    stb = 1'b1;
    #1;
    n_tot++; if (ack !== 1'b1) $display("FAIL ack_follows_stb: got %b want 1", ack); else n_pass++;
    stb = 1'b0;
    #1;
  endtask
  task automatic test_press;
    logic [31:0] d;
    bus_wr(1'b1, 32'h1);
    keys_n[0] = 1'b0;
    sb.push_back(32'h8000_0004);
    tick(19);
    n_tot++; if (irq !== 1'b0) $display("FAIL press_irq_early: got %b want 0", irq); else n_pass++;
    tick(1);
    n_tot++; if (irq !== 1'b1) $display("FAIL press_irq_at_19: got %b want 1", irq); else n_pass++;
    peek(1'b1, d);
    n_tot++; if (d !== 32'h0000_0111) $display("FAIL press_status: got %h want 00000111", d); else n_pass++;
    bus_rd(1'b0, d);
    n_tot++; if (d !== sb[0]) $display("FAIL press_word: got %h want %h", d, sb[0]); else n_pass++;
    void'(sb.pop_front());
    n_tot++; if (irq !== 1'b0) $display("FAIL press_irq_after_read: got %b want 0", irq); else n_pass++;
    bus_rd(1'b0, d);
    n_tot++; if (d !== 32'h0) $display("FAIL press_empty_read: got %h want 0", d); else n_pass++;
    keys_n[0] = 1'b1;
    sb.push_back(32'h8000_0000);
    tick(25);
    bus_rd(1'b0, d);
    n_tot++; if (d !== sb[0]) $display("FAIL release_word: got %h want %h", d, sb[0]); else n_pass++;
    void'(sb.pop_front());
  endtask
  task automatic test_glitch;
    logic [31:0] d;
    keys_n[2] = 1'b0;
    tick(10);
    keys_n[2] = 1'b1;
    tick(30);
    peek(1'b1, d);
    n_tot++; if (d !== 32'h0000_0010) $display("FAIL glitch_status: got %h want 00000010", d); else n_pass++;
  endtask
  task automatic test_order;
    logic [31:0] d;
    keys_n[3] = 1'b0; keys_n[1] = 1'b0;
    sb.push_back(32'h8000_0005);
    sb.push_back(32'h8000_0007);
    tick(25);
    peek(1'b1, d);
    n_tot++; if (d !== 32'h0000_021A) $display("FAIL order_status: got %h want 0000021a", d); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      bus_rd(1'b0, d);
      n_tot++; if (d !== sb[0]) $display("FAIL order_press_%0d: got %h want %h", i, d, sb[0]); else n_pass++;
      void'(sb.pop_front());
    end
    keys_n[3] = 1'b1; keys_n[1] = 1'b1;
    sb.push_back(32'h8000_0001);
    sb.push_back(32'h8000_0003);
    tick(20);
    peek(1'b1, d);
    n_tot++; if (d[13:8] !== 6'd1) $display("FAIL order_count_first: got %0d want 1", d[13:8]); else n_pass++;
    tick(1);
    peek(1'b1, d);
    n_tot++; if (d[13:8] !== 6'd2) $display("FAIL order_count_second: got %0d want 2", d[13:8]); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      bus_rd(1'b0, d);
      n_tot++; if (d !== sb[0]) $display("FAIL order_release_%0d: got %h want %h", i, d, sb[0]); else n_pass++;
      void'(sb.pop_front());
    end
  endtask
  task automatic test_overflow;
    logic [31:0] d;
    keys_n = 4'h0;
    for (int i = 0; i < 4; i++) sb.push_back(32'h8000_0004 | 32'(i));
    tick(25);
    keys_n = 4'hF;
    for (int i = 0; i < 4; i++) sb.push_back(32'h8000_0000 | 32'(i));
    tick(25);
    keys_n[0] = 1'b0;
    tick(25);
    n_tot++; if (irq !== 1'b1) $display("FAIL ovf_irq: got %b want 1", irq); else n_pass++;
    bus_rd(1'b1, d);
    n_tot++; if (d[13:8] !== 6'd8) $display("FAIL ovf_count: got %0d want 8", d[13:8]); else n_pass++;
    n_tot++; if (d[5] !== 1'b1) $display("FAIL ovf_set: got %b want 1", d[5]); else n_pass++;
    bus_rd(1'b1, d);
    n_tot++; if (d[5] !== 1'b0) $display("FAIL ovf_cleared_by_read: got %b want 0", d[5]); else n_pass++;
  endtask
  task automatic test_pop_push_full;
    logic [31:0] d;
    keys_n[0] = 1'b1;
    tick(19);
    bus_rd(1'b0, d);
    n_tot++; if (d !== sb[0]) $display("FAIL popfull_word: got %h want %h", d, sb[0]); else n_pass++;
    void'(sb.pop_front());
    sb.push_back(32'h8000_0000);
    peek(1'b1, d);
    n_tot++; if (d[13:8] !== 6'd8) $display("FAIL popfull_count: got %0d want 8", d[13:8]); else n_pass++;
    n_tot++; if (d[5] !== 1'b0) $display("FAIL popfull_no_ovf: got %b want 0", d[5]); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      bus_rd(1'b0, d);
      n_tot++; if (d !== sb[0]) $display("FAIL drain_%0d: got %h want %h", i, d, sb[0]); else n_pass++;
      void'(sb.pop_front());
    end
    peek(1'b1, d);
    n_tot++; if (d[13:8] !== 6'd0) $display("FAIL drain_count: got %0d want 0", d[13:8]); else n_pass++;
  endtask
  task automatic test_flush;
    logic [31:0] d;
    keys_n[2] = 1'b0;
    tick(19);
    bus_wr(1'b1, 32'h3);
    peek(1'b1, d);
    n_tot++; if (d !== 32'h0000_0014) $display("FAIL flush_status: got %h want 00000014", d); else n_pass++;
    n_tot++; if (irq !== 1'b0) $display("FAIL flush_irq: got %b want 0", irq); else n_pass++;
    tick(3);
    bus_rd(1'b0, d);
    n_tot++; if (d !== 32'h0) $display("FAIL flush_evt: got %h want 0", d); else n_pass++;
    keys_n[2] = 1'b1;
    sb.push_back(32'h8000_0002);
    tick(25);
    bus_rd(1'b0, d);
    n_tot++; if (d !== sb[0]) $display("FAIL flush_after_word: got %h want %h", d, sb[0]); else n_pass++;
    void'(sb.pop_front());
  endtask
  task automatic test_reset_mid;
    logic [31:0] d;
    keys_n[1] = 1'b0;
    tick(8);
    rst_n = 1'b0;
    tick(2);
    keys_n[1] = 1'b1;
    n_tot++; if (irq !== 1'b0) $display("FAIL rstmid_irq_low: got %b want 0", irq); else n_pass++;
    rst_n = 1'b1;
    tick(40);
    peek(1'b1, d);
    n_tot++; if (d !== 32'h0) $display("FAIL rstmid_status: got %h want 0", d); else n_pass++;
    peek(1'b0, d);
    n_tot++; if (d !== 32'h0) $display("FAIL rstmid_evt: got %h want 0", d); else n_pass++;
    n_tot++; if (irq !== 1'b0) $display("FAIL rstmid_irq: got %b want 0", irq); else n_pass++;
  endtask
  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_order();
    test_overflow();
    test_pop_push_full();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/bsw_evq.md
# bsw_evq

Debounced key-event controller for the board's push buttons. It synchronises and debounces the four active-low keys with a per-key state machine. It schedules the resulting press/release events, one per cycle, into a small FIFO that the CPU drains over the single-cycle I/O bus. It raises an interrupt while events are queued and interrupts are enabled.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..32
- DEB_CYCLES, 500000: stable cycles required to accept a level (10 ms at 50 MHz); must be ≥ 8
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- stb  in  1  bus strobe, this device selected
- we  in  1  1 = write, 0 = read
- addr  in  1  0 = event register, 1 = control/status register
- data_in  in  32  write data
- data_out  out  32  read data, combinational
- ack  out  1  equal to stb (single-cycle access)
- irq  out  1  interrupt request, level
- keys_n  in  4  raw buttons, low = pressed, asynchronous

## Operation
- Per key: 2-flop synchroniser feeding a debounce FSM with states UP, CHK_DN, DOWN, CHK_UP.
  - UP: synced pressed → CHK_DN, counter cleared.
  - CHK_DN: synced released → UP, no event; counter == DEB_CYCLES-1 → DOWN plus a press event.
  - DOWN/CHK_UP: symmetric, emitting a release event.
- Each event sets the key's pending flag and type bit.
- Scheduler: each cycle the lowest-index pending key is pushed; its pending flag clears on that same edge.
- FIFO full at push time: event dropped, pending cleared, sticky ovf set.
- Event word: bit31 valid, bits[23:8] timestamp (see Configuration), bit2 type (1 = press), bits[1:0] key index, all other bits 0.
- Read addr 0:
  - FIFO non-empty: returns the head with valid = 1 and pops it.
  - FIFO empty: returns 0 and nothing changes.
- Write addr 0: ignored.
- Read addr 1: {count[5:0] at bits[13:8], ovf bit 5, ien bit 4, debounced key states bits[3:0] (1 = pressed)}. The read clears ovf.
- Write addr 1: bit0 → ien; bit1 = 1 flushes the FIFO and clears all pending flags (self-clearing).
- irq = ien & (count != 0).

## Timing
- Reset: all FSMs UP, counters 0, FIFO empty, pending 0, ovf 0, ien 0, timestamp 0, irq 0.
  - data_out is combinational: 0 for an addr-0 read.
  - ack follows stb.
- Reset is honoured mid-debounce and mid-access. Keys held during reset yield a press event DEB_CYCLES+3 cycles after rst_n deasserts.
- Latency from the first clk edge sampling a new stable raw level to the FIFO push, lone key: DEB_CYCLES+3 cycles. Add 1 cycle per lower-index key pending in the same cycle.
- irq asserts on the edge after the push.
- Pop and push in the same cycle: both performed, count unchanged; a full FIFO accepts the push.
- Flush and push in the same cycle: flush wins, event lost, ovf not set.
- Pop and ovf-set in the same cycle: handled independently.
- Status read and ovf-set in the same cycle: ovf ends at 1.
- A bounce shorter than DEB_CYCLES produces no event.
- DEB_CYCLES ≥ 8 guarantees a key's pending flag drains before that key can emit again.

## Configuration
- BSW_EVQ_TIMESTAMP_EN defined:
  - Free-running 16-bit cycle/1024 counter, wrapping 0xFFFF → 0.
  - Sampled into bits[23:8] at push time.
- BSW_EVQ_TIMESTAMP_EN undefined: counter absent, bits[23:8] read 0.

## Structure
- Package bsw_evq_pkg:
  - FSM state encodings.
  - Event-word bit positions (VALID_BIT, TYPE_BIT, TS_LSB, TS_MSB).
  - Register addresses and control bit positions.
- Sub-module bsw_debounce: synchroniser, FSM and counter for one key; instantiated 4×. It outputs the debounced level and a 1-cycle event pulse with type.
- FIFO, scheduler, register file and timestamp counter live in bsw_evq.

## Test plan
All scenarios use DEB_CYCLES = 16.
- Key 0 pressed and held → press event 0x80000004 readable 19 cycles after the edge; irq = 1 once ien = 1; after the read, irq = 0 and addr 0 reads 0.
- keys_n[2] glitch low for 10 cycles → no event, count stays 0.
- Keys 3 and 1 released simultaneously → FIFO order key 1 then key 3, on consecutive cycles.
- 9 events with DEPTH = 8 and no reads → count 8, ovf = 1; status read returns ovf = 1 and a second read returns 0.
- Read pop on a full FIFO in the same cycle as a push → count stays 8, no ovf.
- Flush write coinciding with a push → count 0, ovf 0; rst_n pulsed mid-CHK_DN → no event, all outputs at reset values.
